// File: rtl/baud_tick_gen.sv
// baud_tick_gen: derives single-cycle oversample (tick_os) and bit-rate
// (tick_bd) enables from the system clock with a fractional phase
// accumulator. A baud-select latch, mid-bit resync, lock indicator and
// unreachable-rate flag sit around the accumulator.
//
// baud_ready handshake: baud_ready is a level. The cycle in which it is
// sampled high after being sampled low is a change request. In that cycle
// baud is captured into baud_cur, the accumulator and oversample counter
// restart from zero, and lock is dropped. Holding baud_ready high, or
// leaving it low, ignores baud. Requesting the current value again still
// restarts the phase.
module baud_tick_gen #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned DEFAULT_SEL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] baud,
    input  logic             baud_ready,
    input  logic             enable,
    input  logic             resync,
    output logic             tick_os,
    output logic             tick_bd,
    output logic [SEL_W-1:0] baud_cur,
    output logic             locked,
    output logic             baud_err
);

    // Oversample counter width; OVERSAMPLE ranges from 2 to 64.
    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IW    = ACC_W + 1;

    localparam logic [CNT_W-1:0] LAST_OS = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF_OS = CNT_W'(OVERSAMPLE / 2);

    // Nominal bit rate for each of the eight select codes.
    function automatic longint unsigned rate_of(input int unsigned idx);
        case (idx)
            0:       rate_of = 64'd1200;
            1:       rate_of = 64'd2400;
            2:       rate_of = 64'd4800;
            3:       rate_of = 64'd9600;
            4:       rate_of = 64'd19200;
            5:       rate_of = 64'd38400;
            6:       rate_of = 64'd57600;
            default: rate_of = 64'd115200;
        endcase
    endfunction

    // Phase increment, rounded to nearest: rate*OVERSAMPLE*2^ACC_W / CLK_HZ.
    // Only ever evaluated on constants, so it folds away at elaboration.
    function automatic logic [ACC_W:0] inc_of(input int unsigned idx);
        longint unsigned num;
        num = rate_of(idx) * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(CLK_HZ / 2);
        return IW'(num / 64'(CLK_HZ));
    endfunction

    // A rate is unreachable when its oversample rate exceeds the clock.
    function automatic logic err_of(input int unsigned idx);
        return (rate_of(idx) * 64'(OVERSAMPLE)) > 64'(CLK_HZ);
    endfunction

    // Codes above 7 (wide select buses) alias the fastest rate.
    function automatic logic [2:0] sel_idx(input logic [SEL_W-1:0] code);
        if (32'(code) > 32'd7) begin
            return 3'd7;
        end
        return 3'(code);
    endfunction

    localparam logic [ACC_W:0] INC_TAB [8] = '{
        inc_of(0), inc_of(1), inc_of(2), inc_of(3),
        inc_of(4), inc_of(5), inc_of(6), inc_of(7)
    };

    localparam logic [7:0] ERR_TAB = {
        err_of(7), err_of(6), err_of(5), err_of(4),
        err_of(3), err_of(2), err_of(1), err_of(0)
    };

    localparam logic [SEL_W-1:0] DEFAULT_CODE = SEL_W'(DEFAULT_SEL);
    localparam logic             DEFAULT_ERR  = ERR_TAB[sel_idx(DEFAULT_CODE)];

    // Registered state
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] os_cnt;
    logic             baud_ready_q;

    // Next-state values
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] os_cnt_d;
    logic             tick_os_d;
    logic             tick_bd_d;
    logic             locked_d;
    logic [SEL_W-1:0] baud_cur_d;
    logic             baud_err_d;

    // Datapath helpers
    logic             ready_rise;
    logic [ACC_W:0]   inc_cur;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             bit_end;

    // Accumulator arithmetic and the change/resync/run priority chain.
    always_comb begin
        ready_rise = baud_ready && !baud_ready_q;
        inc_cur    = INC_TAB[sel_idx(baud_cur)];
        // inc never exceeds 2^ACC_W for a reachable rate and acc < 2^ACC_W,
        // so the top bit of the ACC_W+1 bit sum is exactly the carry.
        sum        = {1'b0, acc} + inc_cur;
        carry      = sum[ACC_W];
        bit_end    = (os_cnt == LAST_OS);

        acc_d      = acc;
        os_cnt_d   = os_cnt;
        tick_os_d  = 1'b0;
        tick_bd_d  = 1'b0;
        locked_d   = locked;
        baud_cur_d = baud_cur;
        baud_err_d = baud_err;

        if (ready_rise) begin
            // Baud change: restart the phase at the start of a bit.
            baud_cur_d = baud;
            baud_err_d = ERR_TAB[sel_idx(baud)];
            acc_d      = '0;
            os_cnt_d   = '0;
            locked_d   = 1'b0;
        end else if (resync) begin
            // Start-bit edge: park the phase half a bit in so the next
            // bit tick lands mid-bit.
            acc_d    = '0;
            os_cnt_d = HALF_OS;
        end else if (enable && !baud_err) begin
            acc_d     = sum[ACC_W-1:0];
            tick_os_d = carry;
            tick_bd_d = carry && bit_end;
            if (carry) begin
                os_cnt_d = bit_end ? '0 : os_cnt + CNT_W'(1);
            end
            if (carry && bit_end) begin
                locked_d = 1'b1;
            end
        end
    end

    // Edge detector for the baud_ready level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_ready_q <= 1'b0;
        end else begin
            baud_ready_q <= baud_ready;
        end
    end

    // Phase, counter, tick and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            os_cnt   <= '0;
            tick_os  <= 1'b0;
            tick_bd  <= 1'b0;
            locked   <= 1'b0;
            baud_cur <= DEFAULT_CODE;
            baud_err <= DEFAULT_ERR;
        end else begin
            acc      <= acc_d;
            os_cnt   <= os_cnt_d;
            tick_os  <= tick_os_d;
            tick_bd  <= tick_bd_d;
            locked   <= locked_d;
            baud_cur <= baud_cur_d;
            baud_err <= baud_err_d;
        end
    end

    // Structural invariants of the outputs.
    bd_implies_os : assert property (@(posedge clk) disable iff (rst) tick_bd |-> tick_os);
    err_no_tick   : assert property (@(posedge clk) disable iff (rst) baud_err |-> !tick_os);
    err_no_lock   : assert property (@(posedge clk) disable iff (rst) baud_err |-> !locked);

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: two builds (OVERSAMPLE 16 and 32) at
// CLK_HZ=1_843_200, ACC_W=16 share one stimulus stream. A rate-level model
// predicts every output on every cycle; directed sequences add literal
// latency/spacing expectations.
module tb_baud_tick_gen;

  localparam int CLK_HZ = 1_843_200;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] baud;
  logic       baud_ready;
  logic       enable;
  logic       resync;

  logic       tick_os16, tick_bd16, locked16, baud_err16;
  logic [2:0] baud_cur16;
  logic       tick_os32, tick_bd32, locked32, baud_err32;
  logic [2:0] baud_cur32;

  int n_checks = 0;
  int n_errors = 0;

  baud_tick_gen #(
    .CLK_HZ(CLK_HZ), .OVERSAMPLE(16), .ACC_W(16), .SEL_W(3), .DEFAULT_SEL(3)
  ) dut16 (
    .clk(clk), .rst(rst), .baud(baud), .baud_ready(baud_ready),
    .enable(enable), .resync(resync), .tick_os(tick_os16), .tick_bd(tick_bd16),
    .baud_cur(baud_cur16), .locked(locked16), .baud_err(baud_err16)
  );

  baud_tick_gen #(
    .CLK_HZ(CLK_HZ), .OVERSAMPLE(32), .ACC_W(16), .SEL_W(3), .DEFAULT_SEL(3)
  ) dut32 (
    .clk(clk), .rst(rst), .baud(baud), .baud_ready(baud_ready),
    .enable(enable), .resync(resync), .tick_os(tick_os32), .tick_bd(tick_bd32),
    .baud_cur(baud_cur32), .locked(locked32), .baud_err(baud_err32)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- rate-level model ----------------
  function automatic longint rate_of(input int sel);
    case (sel)
      0: return 1200;
      1: return 2400;
      2: return 4800;
      3: return 9600;
      4: return 19200;
      5: return 38400;
      6: return 57600;
      default: return 115200;
    endcase
  endfunction

  function automatic longint rate_inc(input int sel, input int os);
    return (rate_of(sel) * os * 65536 + CLK_HZ / 2) / CLK_HZ;
  endfunction

  function automatic logic rate_err(input int sel, input int os);
    return (rate_of(sel) * os) > CLK_HZ;
  endfunction

  // The phase is tracked as a count of increments since the last restart:
  // after n increments from zero, floor(n*inc/2^16) oversample ticks have
  // occurred, and a bit tick is every tick that brings the oversample
  // position (starting offset + ticks) to a multiple of OVERSAMPLE.
  longint     m_n[2];
  int         m_start[2];
  logic       m_rq[2];
  logic       m_locked[2];
  logic       m_err[2];
  logic [2:0] m_cur[2];

  task automatic model_step(input int i, input logic a_os, input logic a_bd,
                            input logic [2:0] a_cur, input logic a_lock, input logic a_err);
    int     os;
    longint inc, k0, k1;
    logic   rise, e_os, e_bd;
    os   = (i == 0) ? 16 : 32;
    e_os = 1'b0;
    e_bd = 1'b0;
    if (rst) begin
      m_rq[i] = 1'b0; m_cur[i] = 3'd3; m_err[i] = rate_err(3, os);
      m_n[i] = 0; m_start[i] = 0; m_locked[i] = 1'b0;
    end else begin
      rise    = baud_ready && !m_rq[i];
      m_rq[i] = baud_ready;
      if (rise) begin
        m_cur[i] = baud; m_err[i] = rate_err(int'(baud), os);
        m_n[i] = 0; m_start[i] = 0; m_locked[i] = 1'b0;
      end else if (resync) begin
        m_n[i] = 0; m_start[i] = os / 2;
      end else if (enable && !m_err[i]) begin
        inc = rate_inc(int'(m_cur[i]), os);
        k0  = (m_n[i] * inc) >> 16;
        m_n[i]++;
        k1  = (m_n[i] * inc) >> 16;
        if (k1 != k0) begin
          e_os = 1'b1;
          if (((longint'(m_start[i]) + k1) % os) == 0) begin
            e_bd = 1'b1;
            m_locked[i] = 1'b1;
          end
        end
      end
    end
    check($sformatf("os%0d_tick_os", os), a_os, e_os);
    check($sformatf("os%0d_tick_bd", os), a_bd, e_bd);
    check($sformatf("os%0d_baud_cur", os), a_cur, m_cur[i]);
    check($sformatf("os%0d_locked", os), a_lock, m_locked[i]);
    check($sformatf("os%0d_baud_err", os), a_err, m_err[i]);
  endtask

  // Compare process: one cycle-accurate check per clock, shortly after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step(0, tick_os16, tick_bd16, baud_cur16, locked16, baud_err16);
      model_step(1, tick_os32, tick_bd32, baud_cur32, locked32, baud_err32);
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for the next tick on dut16 (tick_bd if want_bd, else tick_os);
  // cyc counts clock edges, the first edge after the call being 1.
  task automatic wait_tick(input string name, input bit want_bd, input int limit, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(posedge clk);
      #2;
      cyc++;
      hit = want_bd ? tick_bd16 : tick_os16;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL %s: got no tick expected one within %0d cycles", name, limit);
      cyc = -1;
    end
  endtask

  // Presents a baud_ready rising edge for one cycle; the latch edge is the
  // first posedge after the call. Returns at the following negedge, where
  // the latch-cycle outputs are checked.
  task automatic latch(input logic [2:0] code, input logic with_resync, input string tag);
    @(negedge clk);
    baud = code; baud_ready = 1'b1; resync = with_resync;
    @(negedge clk);
    check({tag, "_latch_tick_os"}, tick_os16, 0);
    check({tag, "_latch_tick_bd"}, tick_bd16, 0);
    check({tag, "_latch_locked"}, locked16, 0);
    check({tag, "_latch_baud_cur"}, baud_cur16, code);
    baud_ready = 1'b0; resync = 1'b0;
  endtask

  // ---------------- directed sequences ----------------
  int   cyc, t, first, last, gmin, gmax, bd_cnt, bd_bad, os_ones, cnt_a, cnt_b;
  logic lock15, lock16;

  initial begin
    rst = 1'b0; baud = 3'd0; baud_ready = 1'b0; enable = 1'b1; resync = 1'b0;

    // Model pins against hand-computed table entries.
    check("model_inc_9600_os16", rate_inc(3, 16), 5461);
    check("model_inc_115200_os16", rate_inc(7, 16), 65536);
    check("model_err_115200_os32", rate_err(7, 32), 1);
    check("model_err_57600_os32", rate_err(6, 32), 0);

    // Reset takes effect without a clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_tick_os", tick_os16, 0);
    check("rst_tick_bd", tick_bd16, 0);
    check("rst_locked", locked16, 0);
    check("rst_baud_cur", baud_cur16, 3);
    check("rst_baud_err", baud_err16, 0);
    check("rst_baud_cur_os32", baud_cur32, 3);
    check("rst_baud_err_os32", baud_err32, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 9600 baud, inc 5461: carry on the 13th increment after the latch
    // edge (the 14th cycle counting the latch cycle), then every 12.
    latch(3'd3, 1'b0, "b3");
    t = 0; first = 0; last = 0; gmin = 1000; gmax = 0; bd_cnt = 0; bd_bad = 0;
    lock15 = 1'bx; lock16 = 1'bx;
    for (int c = 1; c <= 1400 && t < 101; c++) begin
      @(posedge clk);
      #2;
      if (tick_os16) begin
        t++;
        if (t == 1) first = c;
        else begin
          if (c - last < gmin) gmin = c - last;
          if (c - last > gmax) gmax = c - last;
        end
        last = c;
        if (tick_bd16) begin
          bd_cnt++;
          if (t % 16 != 0) bd_bad++;
        end
        if (t == 15) lock15 = locked16;
        if (t == 16) lock16 = locked16;
      end
    end
    check("b3_first_os_edge", first, 13);
    check("b3_gap_min", gmin, 12);
    check("b3_gap_max", gmax, 12);
    check("b3_bd_count", bd_cnt, 6);
    check("b3_bd_off_16th", bd_bad, 0);
    check("b3_locked_before_bd", lock15, 0);
    check("b3_locked_at_bd", lock16, 1);

    // Switch 3 -> 7 with the oversample position at 9.
    wait_tick("sync_bd_b3", 1'b1, 300, cyc);
    repeat (9) wait_tick("sync_os_b3", 1'b0, 20, cyc);
    latch(3'd7, 1'b0, "to7");
    first = 0; os_ones = 0; bd_cnt = 0; lock15 = 1'bx; lock16 = 1'bx;
    for (int i = 1; i <= 48; i++) begin
      @(posedge clk);
      #2;
      if (tick_os16) os_ones++;
      if (tick_bd16) begin
        bd_cnt++;
        if (first == 0) first = i;
      end
      if (i == 15) lock15 = locked16;
      if (i == 16) lock16 = locked16;
    end
    check("to7_first_bd_edge", first, 16);
    check("to7_os_every_cycle", os_ones, 48);
    check("to7_bd_count", bd_cnt, 3);
    check("to7_locked_before_bd", lock15, 0);
    check("to7_locked_at_bd", lock16, 1);
    check("to7_baud_err", baud_err16, 0);

    // The OVERSAMPLE=32 build cannot reach 115200: silent and unlocked.
    check("os32_b7_baud_err", baud_err32, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (1000) begin
      @(posedge clk);
      #2;
      if (tick_os32 || tick_bd32) cnt_a++;
      if (locked32) cnt_b++;
    end
    check("os32_b7_ticks", cnt_a, 0);
    check("os32_b7_locked_cycles", cnt_b, 0);

    // Resync at oversample position 3: bit tick 8 edges later.
    wait_tick("sync_bd_b7", 1'b1, 20, cyc);
    repeat (3) wait_tick("sync_os_b7", 1'b0, 2, cyc);
    @(negedge clk);
    resync = 1'b1;
    @(negedge clk);
    check("rs_tick_os", tick_os16, 0);
    check("rs_tick_bd", tick_bd16, 0);
    check("rs_locked_kept", locked16, 1);
    resync = 1'b0;
    wait_tick("rs_bd", 1'b1, 20, cyc);
    check("rs_bd_edge", cyc, 8);

    // Resync together with a same-value baud change: the change wins.
    repeat (5) wait_tick("sync_os_b7b", 1'b0, 2, cyc);
    latch(3'd7, 1'b1, "rs_chg");
    wait_tick("rs_chg_bd", 1'b1, 30, cyc);
    check("rs_chg_bd_edge", cyc, 16);

    // 57600 is reachable at OVERSAMPLE=32 (inc 65536): ticks every cycle.
    latch(3'd6, 1'b0, "to6");
    check("os32_b6_baud_err", baud_err32, 0);
    check("os32_b6_baud_cur", baud_cur32, 6);
    cnt_a = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #2;
      if (tick_os32) cnt_a++;
    end
    check("os32_b6_ticks", cnt_a, 20);

    // Asynchronous reset mid-bit, while tick_os and locked are high.
    wait_tick("pre_rst_bd", 1'b1, 80, cyc);
    wait_tick("pre_rst_os", 1'b0, 4, cyc);
    #1 rst = 1'b1;
    #1;
    check("arst_tick_os", tick_os16, 0);
    check("arst_tick_bd", tick_bd16, 0);
    check("arst_locked", locked16, 0);
    check("arst_baud_cur", baud_cur16, 3);
    check("arst_baud_err", baud_err16, 0);
    check("arst_tick_os_os32", tick_os32, 0);
    check("arst_locked_os32", locked32, 0);
    check("arst_baud_cur_os32", baud_cur32, 3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // enable=0 for 50 cycles right after a tick: no ticks, then the
    // held phase completes the remaining 12-increment interval.
    repeat (3) wait_tick("pre_en_os", 1'b0, 20, cyc);
    @(negedge clk);
    enable = 1'b0;
    cnt_a = 0;
    repeat (50) begin
      @(posedge clk);
      #2;
      if (tick_os16 || tick_bd16 || tick_os32 || tick_bd32) cnt_a++;
    end
    check("en0_ticks", cnt_a, 0);
    @(negedge clk);
    enable = 1'b1;
    wait_tick("en1_os", 1'b0, 40, cyc);
    check("en1_first_os_edge", cyc, 12);
    wait_tick("en1_os2", 1'b0, 40, cyc);
    check("en1_gap", cyc, 12);

    // baud is ignored while baud_ready stays high and while it is low.
    @(negedge clk);
    baud = 3'd5; baud_ready = 1'b1;
    @(negedge clk);
    baud = 3'd1;
    repeat (4) @(negedge clk);
    check("held_ready_baud_cur", baud_cur16, 5);
    baud_ready = 1'b0; baud = 3'd2;
    repeat (3) @(negedge clk);
    check("low_ready_baud_cur", baud_cur16, 5);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
